spike_output_collector: RTL and testbench
=========================================

Name: spike_output_collector

Overview:
- Clocked output stage directly downstream of the partial-sum/NoC output port; consumes the 64-bit partial-sum packets the mesh delivers to the output node.
- Per output neuron, integrates partial sums into a membrane potential per timestep and applies threshold/subtract-reset.
- Emits one spike bitmap per timestep over a valid/ready handshake, then pulses done after the last timestep.

Parameters:
- OUT_DIM, 3, output feature map is OUT_DIM x OUT_DIM neurons (max 15).
- TIMESTEPS, 2, timesteps per inference (max 4).
- PSUM_W, 13, width of the unsigned partial-sum payload.
- THRESHOLD, 64, firing threshold (unsigned, < 2^PSUM_W).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  packet valid from NoC output interface.
- in_ready  out  1  collector accepts packet this cycle.
- in_data  in  64  packet; [55:54] type (2'b10 = partial sum), [47:44] row, [43:40] col, [39:38] timestep, [PSUM_W-1:0] psum; other bits ignored.
- out_valid  out  1  spike bitmap valid.
- out_ready  in  1  downstream accepts bitmap.
- out_spikes  out  OUT_DIM*OUT_DIM  spike bitmap; bit index = row*OUT_DIM+col.
- out_timestep  out  2  timestep of out_spikes.
- done  out  1  one-cycle pulse after final bitmap handshake.
- drop_count  out  8  saturating count of rejected packets.
- busy  out  1  high from first accepted packet until done.

Behaviour:
- Reset: all potentials V[i]=0, received flags=0, spike map=0, timestep=0, state COLLECT; outputs in_ready=1, out_valid=0, out_spikes=0, out_timestep=0, done=0, drop_count=0, busy=0. Reset mid-operation discards all state in one cycle; partial maps are never emitted.
- V[i] width PSUM_W+1, unsigned, saturating at 2^(PSUM_W+1)-1.
- States:
  - COLLECT: in_ready=1. Packet accepted on in_valid&&in_ready.
  - EMIT: in_ready=0, out_valid=1, out_spikes/out_timestep held stable until out_ready.
  - DONE: one cycle; done=1, in_ready=0.
- Packet accept (COLLECT): valid iff type==2'b10 AND row<OUT_DIM AND col<OUT_DIM AND timestep field == current timestep AND received[i]==0. A valid packet updates the neuron next edge: S=V[i]+psum (saturated); if S>=THRESHOLD then spike[i]=1, V[i]=S-THRESHOLD, else V[i]=S; received[i]=1; busy=1. An invalid packet is consumed (handshake completes), state unchanged, drop_count+=1 (saturates at 255).
- Transition COLLECT->EMIT on the edge that accepts the last outstanding neuron; out_valid is high the following cycle (1-cycle latency from last packet).
- EMIT handshake (out_valid&&out_ready): clear spike map and received flags. If timestep==TIMESTEPS-1 go to DONE, else timestep+=1 and return to COLLECT.
- DONE->COLLECT next cycle: V[i]=0, timestep=0, busy=0, drop_count retained.
- One packet per cycle max; no internal buffering beyond neuron state; back-pressure via in_ready only.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, drop_count=0, no state change from input.
- Timestep 0: psum 70 to (0,0), 10 to other 8 neurons -> one cycle after 9th accept out_valid=1, out_spikes=9'b000000001, out_timestep=0; V(0,0)=6, others 10.
- Timestep 1: psum 58 to (0,0), 54 to (2,2), 0 elsewhere -> out_spikes=9'b100000001, out_timestep=1; after handshake done pulses exactly 1 cycle, busy falls, V all 0.
- Drops: during timestep 0 send type 2'b01, row=3, timestep=1, and a duplicate (1,1) -> drop_count=4, all accepted with in_ready=1, bitmap unaffected.
- Back-pressure: hold out_ready=0 for 5 cycles in EMIT with in_valid=1 -> in_ready=0, out_spikes/out_timestep stable, no packet consumed; release -> single handshake.
- Reset mid-op: assert reset after 5 of 9 packets in timestep 1 -> next cycle all outputs at reset values; fresh full run reproduces scenario 2 exactly.

Source files
------------

// File: rtl/spike_output_collector.sv
// spike_output_collector
//   Output stage behind the partial-sum NoC port. Integrates partial sums into
//   per-neuron membrane potentials for each timestep, fires with
//   subtract-reset at THRESHOLD, and hands one spike bitmap per timestep
//   downstream over valid/ready. After the last timestep it pulses done.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : packet handshake from the NoC output interface
//   in_data[63:0]       : [55:54] type, [47:44] row, [43:40] col,
//                         [39:38] timestep, [PSUM_W-1:0] unsigned psum
//   out_valid/out_ready : spike bitmap handshake
//   out_spikes          : bitmap, bit index = row*OUT_DIM+col
//   out_timestep        : timestep of out_spikes
//   done                : one-cycle pulse after the final bitmap handshake
//   drop_count          : saturating count of rejected packets
//   busy                : high from first accepted packet until done
module spike_output_collector #(
  parameter int unsigned OUT_DIM   = 3,
  parameter int unsigned TIMESTEPS = 2,
  parameter int unsigned PSUM_W    = 13,
  parameter int unsigned THRESHOLD = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [63:0]                  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_DIM*OUT_DIM-1:0]   out_spikes,
  output logic [1:0]                   out_timestep,
  output logic                         done,
  output logic [7:0]                   drop_count,
  output logic                         busy
);

  localparam int unsigned N  = OUT_DIM * OUT_DIM;
  localparam int unsigned VW = PSUM_W + 1;

  localparam logic [3:0]    DIM4    = 4'(OUT_DIM);
  localparam logic [7:0]    DIM8    = 8'(OUT_DIM);
  localparam logic [1:0]    LAST_TS = 2'(TIMESTEPS - 1);
  localparam logic [VW-1:0] THR     = VW'(THRESHOLD);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EMIT    = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               st_q, st_d;
  logic [N-1:0][VW-1:0] v_q, v_d;
  logic [N-1:0]         recv_q, recv_d;
  logic [N-1:0]         spk_q, spk_d;
  logic [1:0]           ts_q, ts_d;
  logic [7:0]           drop_q, drop_d;
  logic                 busy_q, busy_d;

  // Packet fields
  logic [1:0]        pkt_type;
  logic [3:0]        pkt_row, pkt_col;
  logic [1:0]        pkt_ts;
  logic [PSUM_W-1:0] pkt_psum;
  logic              unused_in_bits;

  assign pkt_type       = in_data[55:54];
  assign pkt_row        = in_data[47:44];
  assign pkt_col        = in_data[43:40];
  assign pkt_ts         = in_data[39:38];
  assign pkt_psum       = in_data[PSUM_W-1:0];
  assign unused_in_bits = ^{in_data[63:56], in_data[53:48], in_data[37:PSUM_W]};

  logic [7:0]    idx;
  logic [N-1:0]  sel;
  logic          addr_ok;
  logic          hit;
  logic [VW-1:0] v_sel;
  logic [VW:0]   sum;
  logic [VW-1:0] sat;
  logic [VW-1:0] v_new;
  logic          fire;

  // Neuron update datapath: one-hot select, saturating add, subtract-reset.
  always_comb begin
    idx     = 8'(pkt_row) * DIM8 + 8'(pkt_col);
    addr_ok = (pkt_type == 2'b10) && (pkt_row < DIM4) && (pkt_col < DIM4) &&
              (pkt_ts == ts_q);
    sel     = '0;
    v_sel   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel[i] = (idx == 8'(i));
      if (sel[i]) v_sel = v_q[i];
    end
    // An out-of-range address leaves sel all-zero, but addr_ok already fails.
    hit   = addr_ok && ((sel & recv_q) == '0);
    sum   = {1'b0, v_sel} + (VW + 1)'(pkt_psum);
    sat   = sum[VW] ? '1 : sum[VW-1:0];
    fire  = (sat >= THR);
    v_new = fire ? (sat - THR) : sat;
  end

  // Next-state and datapath control
  always_comb begin
    st_d   = st_q;
    v_d    = v_q;
    recv_d = recv_q;
    spk_d  = spk_q;
    ts_d   = ts_q;
    drop_d = drop_q;
    busy_d = busy_q;
    unique case (st_q)
      S_COLLECT: begin
        if (in_valid) begin
          if (hit) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (sel[i]) begin
                v_d[i]   = v_new;
                spk_d[i] = fire;
              end
            end
            recv_d = recv_q | sel;
            busy_d = 1'b1;
            if (&recv_d) st_d = S_EMIT;
          end else if (drop_q != '1) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          spk_d  = '0;
          recv_d = '0;
          if (ts_q == LAST_TS) begin
            st_d = S_DONE;
          end else begin
            ts_d = ts_q + 2'd1;
            st_d = S_COLLECT;
          end
        end
      end
      S_DONE: begin
        st_d   = S_COLLECT;
        v_d    = '0;
        ts_d   = '0;
        busy_d = 1'b0;
      end
      default: st_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= S_COLLECT;
      v_q    <= '0;
      recv_q <= '0;
      spk_q  <= '0;
      ts_q   <= '0;
      drop_q <= '0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      v_q    <= v_d;
      recv_q <= recv_d;
      spk_q  <= spk_d;
      ts_q   <= ts_d;
      drop_q <= drop_d;
      busy_q <= busy_d;
    end
  end

  assign in_ready     = (st_q == S_COLLECT);
  assign out_valid    = (st_q == S_EMIT);
  assign out_spikes   = (st_q == S_EMIT) ? spk_q : '0;
  assign out_timestep = ts_q;
  assign done         = (st_q == S_DONE);
  assign drop_count   = drop_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spike_output_collector.sv
module tb_spike_output_collector;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_spikes;
  logic [1:0]  out_timestep;
  logic        done;
  logic [7:0]  drop_count;
  logic        busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [12:0] pmap [9];

  spike_output_collector #(
    .OUT_DIM  (3),
    .TIMESTEPS(2),
    .PSUM_W   (13),
    .THRESHOLD(64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_spikes  (out_spikes),
    .out_timestep(out_timestep),
    .done        (done),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pkt(input logic [1:0] ty, input logic [3:0] r,
                                      input logic [3:0] c, input logic [1:0] t,
                                      input logic [12:0] p);
    logic [63:0] d;
    d        = '0;
    d[55:54] = ty;
    d[47:44] = r;
    d[43:40] = c;
    d[39:38] = t;
    d[12:0]  = p;
    return d;
  endfunction

  // Present one packet and hold it until the handshake edge (bounded).
  task automatic send(input logic [63:0] d);
    int unsigned w;
    w        = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_all(input logic [1:0] t, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      send(pkt(2'b10, 4'(i / 3), 4'(i % 3), t, pmap[i]));
  endtask

  task automatic handshake();
    int unsigned w;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 20) begin
      tests++; fails++;
      $display("FAIL hs_timeout: out_valid=%b required 1", out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = pkt(2'b10, 4'd0, 4'd0, 2'd0, 13'd70);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b1)       begin fails++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0)      begin fails++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    tests++; if (drop_count !== 8'd0)     begin fails++; $display("FAIL rst_drop: got %0d exp 0", drop_count); end
    tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
    tests++; if (done !== 1'b0)           begin fails++; $display("FAIL rst_done: got %b exp 0", done); end
    tests++; if (out_spikes !== 9'd0)     begin fails++; $display("FAIL rst_spikes: got %b exp 0", out_spikes); end
    tests++; if (out_timestep !== 2'd0)   begin fails++; $display("FAIL rst_ts: got %0d exp 0", out_timestep); end
  endtask

  // Timestep 0 with four rejected packets interleaved.
  task automatic test_ts0_drops();
    send(pkt(2'b10, 4'd0, 4'd0, 2'd0, 13'd70));
    send(pkt(2'b01, 4'd0, 4'd1, 2'd0, 13'd10));  // wrong type
    send(pkt(2'b10, 4'd0, 4'd1, 2'd0, 13'd10));
    send(pkt(2'b10, 4'd3, 4'd0, 2'd0, 13'd10));  // row out of range
    send(pkt(2'b10, 4'd0, 4'd2, 2'd0, 13'd10));
    send(pkt(2'b10, 4'd1, 4'd0, 2'd1, 13'd10));  // wrong timestep
    send(pkt(2'b10, 4'd1, 4'd0, 2'd0, 13'd10));
    send(pkt(2'b10, 4'd1, 4'd1, 2'd0, 13'd10));
    send(pkt(2'b10, 4'd1, 4'd1, 2'd0, 13'd10));  // duplicate
    send(pkt(2'b10, 4'd1, 4'd2, 2'd0, 13'd10));
    send(pkt(2'b10, 4'd2, 4'd0, 2'd0, 13'd10));
    send(pkt(2'b10, 4'd2, 4'd1, 2'd0, 13'd10));
    tests++; if (out_valid !== 1'b0)   begin fails++; $display("FAIL ts0_early_valid: got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL ts0_in_ready: got %b exp 1", in_ready); end
    tests++; if (busy !== 1'b1)        begin fails++; $display("FAIL ts0_busy: got %b exp 1", busy); end
    send(pkt(2'b10, 4'd2, 4'd2, 2'd0, 13'd10));
    tests++; if (out_valid !== 1'b1)         begin fails++; $display("FAIL ts0_valid: got %b exp 1", out_valid); end
    tests++; if (out_spikes !== 9'b000000001) begin fails++; $display("FAIL ts0_spikes: got %b exp 000000001", out_spikes); end
    tests++; if (out_timestep !== 2'd0)      begin fails++; $display("FAIL ts0_ts: got %0d exp 0", out_timestep); end
    tests++; if (drop_count !== 8'd4)        begin fails++; $display("FAIL ts0_drop: got %0d exp 4", drop_count); end
    tests++; if (in_ready !== 1'b0)          begin fails++; $display("FAIL ts0_emit_ready: got %b exp 0", in_ready); end
  endtask

  task automatic test_backpressure();
    in_valid  = 1'b1;
    in_data   = pkt(2'b10, 4'd0, 4'd0, 2'd0, 13'd100);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      tests++; if (in_ready !== 1'b0)           begin fails++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
      tests++; if (out_valid !== 1'b1)          begin fails++; $display("FAIL bp_valid: got %b exp 1", out_valid); end
      tests++; if (out_spikes !== 9'b000000001) begin fails++; $display("FAIL bp_spikes: got %b exp 000000001", out_spikes); end
      tests++; if (out_timestep !== 2'd0)       begin fails++; $display("FAIL bp_ts: got %0d exp 0", out_timestep); end
      tests++; if (drop_count !== 8'd4)         begin fails++; $display("FAIL bp_drop: got %0d exp 4", drop_count); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0)     begin fails++; $display("FAIL bp_release_valid: got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1)      begin fails++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
    tests++; if (out_timestep !== 2'd1)  begin fails++; $display("FAIL bp_next_ts: got %0d exp 1", out_timestep); end
    tests++; if (done !== 1'b0)          begin fails++; $display("FAIL bp_done: got %b exp 0", done); end
  endtask

  // Timestep 1: V(0,0)=6+58 and V(2,2)=10+54 both reach 64 exactly.
  task automatic test_ts1_done(input logic [7:0] exp_drop);
    for (int i = 0; i < 9; i++) pmap[i] = 13'd0;
    pmap[0] = 13'd58;
    pmap[8] = 13'd54;
    send_all(2'd1, 9);
    tests++; if (out_valid !== 1'b1)          begin fails++; $display("FAIL ts1_valid: got %b exp 1", out_valid); end
    tests++; if (out_spikes !== 9'b100000001) begin fails++; $display("FAIL ts1_spikes: got %b exp 100000001", out_spikes); end
    tests++; if (out_timestep !== 2'd1)       begin fails++; $display("FAIL ts1_ts: got %0d exp 1", out_timestep); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (done !== 1'b1)      begin fails++; $display("FAIL done_pulse: got %b exp 1", done); end
    tests++; if (busy !== 1'b1)      begin fails++; $display("FAIL done_busy: got %b exp 1", busy); end
    tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL done_in_ready: got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL done_valid: got %b exp 0", out_valid); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0)          begin fails++; $display("FAIL done_width: got %b exp 0", done); end
    tests++; if (busy !== 1'b0)          begin fails++; $display("FAIL busy_fall: got %b exp 0", busy); end
    tests++; if (in_ready !== 1'b1)      begin fails++; $display("FAIL post_done_ready: got %b exp 1", in_ready); end
    tests++; if (out_timestep !== 2'd0)  begin fails++; $display("FAIL post_done_ts: got %0d exp 0", out_timestep); end
    tests++; if (drop_count !== exp_drop) begin fails++; $display("FAIL post_done_drop: got %0d exp %0d", drop_count, exp_drop); end
  endtask

  // 54 to every neuron: any potential left over from the previous run
  // (10 on the non-spiking neurons) would push them to 64 and fire.
  task automatic test_v_cleared();
    for (int i = 0; i < 9; i++) pmap[i] = 13'd54;
    send_all(2'd0, 9);
    tests++; if (out_spikes !== 9'd0) begin fails++; $display("FAIL v_cleared_spikes: got %b exp 0", out_spikes); end
    handshake();
  endtask

  task automatic test_reset_midop();
    pmap[0] = 13'd58;
    for (int i = 1; i < 9; i++) pmap[i] = 13'd0;
    send_all(2'd1, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (in_ready !== 1'b1)     begin fails++; $display("FAIL mid_rst_ready: got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0)    begin fails++; $display("FAIL mid_rst_valid: got %b exp 0", out_valid); end
    tests++; if (out_spikes !== 9'd0)   begin fails++; $display("FAIL mid_rst_spikes: got %b exp 0", out_spikes); end
    tests++; if (out_timestep !== 2'd0) begin fails++; $display("FAIL mid_rst_ts: got %0d exp 0", out_timestep); end
    tests++; if (done !== 1'b0)         begin fails++; $display("FAIL mid_rst_done: got %b exp 0", done); end
    tests++; if (drop_count !== 8'd0)   begin fails++; $display("FAIL mid_rst_drop: got %0d exp 0", drop_count); end
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL mid_rst_busy: got %b exp 0", busy); end
    // Fresh run of the baseline scenario without drops.
    pmap[0] = 13'd70;
    for (int i = 1; i < 9; i++) pmap[i] = 13'd10;
    send_all(2'd0, 9);
    tests++; if (out_spikes !== 9'b000000001) begin fails++; $display("FAIL rerun_ts0_spikes: got %b exp 000000001", out_spikes); end
    tests++; if (out_timestep !== 2'd0)       begin fails++; $display("FAIL rerun_ts0_ts: got %0d exp 0", out_timestep); end
    handshake();
    test_ts1_done(8'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    test_reset();
    test_ts0_drops();
    test_backpressure();
    test_ts1_done(8'd4);
    test_v_cleared();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
